// File: rtl/mul_accumulator.sv
// mul_accumulator: sums fixed-length groups of LEN unsigned products taken
// over a valid/ready handshake and presents each group total on a held,
// handshaked result register.
//
// Build option: define MAC_SAT_EN to clamp the accumulator at 2^ACC_W-1 on
// carry out. Otherwise the sum wraps modulo 2^ACC_W. In both builds a carry
// out sets the sticky ovf flag.
//
// Note: the reset port is called rst_n for compatibility with the surrounding
// datapath, but it is asynchronous and active-high.
module mul_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [7:0]        count,
  output logic              ovf
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Count value at which the next accept completes the group.
  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  state_t             state_r;
  state_t             state_next_s;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   acc_next_s;
  logic [7:0]         count_r;
  logic [7:0]         count_next_s;
  logic [ACC_W-1:0]   acc_out_r;
  logic [ACC_W-1:0]   acc_out_next_s;
  logic               acc_valid_r;
  logic               acc_valid_next_s;
  logic               ovf_r;
  logic               ovf_next_s;
  logic               ready_r;
  logic               ready_next_s;

  logic               accept_s;
  logic [ACC_W:0]     sum_s;
  logic               carry_s;
  logic [ACC_W-1:0]   add_res_s;

  // Widened add so the carry out of bit ACC_W-1 is visible.
  always_comb begin
    sum_s   = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    carry_s = sum_s[ACC_W];
  end

  // Apply the overflow policy to the raw sum.
  always_comb begin
`ifdef MAC_SAT_EN
    if (carry_s) begin
      add_res_s = {ACC_W{1'b1}};
    end else begin
      add_res_s = sum_s[ACC_W-1:0];
    end
`else
    add_res_s = sum_s[ACC_W-1:0];
`endif
  end

  // A product is taken only when it is offered and the block is collecting.
  always_comb begin
    accept_s = prod_valid && ready_r;
  end

  // Next-state and datapath update; clear overrides accept and handshake.
  always_comb begin
    state_next_s     = state_r;
    acc_next_s       = acc_r;
    count_next_s     = count_r;
    acc_out_next_s   = acc_out_r;
    acc_valid_next_s = acc_valid_r;
    ovf_next_s       = ovf_r;
    if (clear) begin
      state_next_s     = ST_ACC;
      acc_next_s       = {ACC_W{1'b0}};
      count_next_s     = 8'd0;
      acc_valid_next_s = 1'b0;
      ovf_next_s       = 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (accept_s) begin
            ovf_next_s = ovf_r | carry_s;
            if (count_r == LAST_CNT) begin
              acc_out_next_s   = add_res_s;
              acc_valid_next_s = 1'b1;
              acc_next_s       = {ACC_W{1'b0}};
              count_next_s     = 8'd0;
              state_next_s     = ST_HOLD;
            end else begin
              acc_next_s   = add_res_s;
              count_next_s = count_r + 8'd1;
            end
          end else begin
            state_next_s = ST_ACC;
          end
        end
        ST_HOLD: begin
          if (acc_ready) begin
            acc_valid_next_s = 1'b0;
            ovf_next_s       = 1'b0;
            state_next_s     = ST_ACC;
          end else begin
            state_next_s = ST_HOLD;
          end
        end
        default: begin
          state_next_s = ST_ACC;
        end
      endcase
    end
  end

  // prod_ready is a registered decode of the upcoming state, so it is low
  // during reset and has no path from prod_valid or acc_ready.
  always_comb begin
    ready_next_s = (state_next_s == ST_ACC);
  end

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= ST_ACC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc_r       <= {ACC_W{1'b0}};
      count_r     <= 8'd0;
      acc_out_r   <= {ACC_W{1'b0}};
      acc_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      acc_r       <= acc_next_s;
      count_r     <= count_next_s;
      acc_out_r   <= acc_out_next_s;
      acc_valid_r <= acc_valid_next_s;
      ovf_r       <= ovf_next_s;
      ready_r     <= ready_next_s;
    end
  end

  assign prod_ready = ready_r;
  assign acc_out    = acc_out_r;
  assign acc_valid  = acc_valid_r;
  assign count      = count_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_mul_accumulator.sv
// Self-checking bench for mul_accumulator. Three instances share one input
// stream: A (LEN=4, ACC_W=16), B (LEN=4, ACC_W=9) and C (LEN=1, ACC_W=16).
module tb_mul_accumulator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  prod;
  logic        prod_valid;
  logic        clear;
  logic        acc_ready;

  logic        a_ready, a_valid, a_ovf;
  logic [15:0] a_acc;
  logic [7:0]  a_count;
  logic        b_ready, b_valid, b_ovf;
  logic [8:0]  b_acc;
  logic [7:0]  b_count;
  logic        c_ready, c_valid, c_ovf;
  logic [15:0] c_acc;
  logic [7:0]  c_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MAC_SAT_EN
  localparam int B_G1 = 511;
  localparam int B_G2 = 511;
`else
  localparam int B_G1 = 508;
  localparam int B_G2 = 253;
`endif

  mul_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) u_a (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid),
    .prod_ready(a_ready), .clear(clear), .acc_out(a_acc), .acc_valid(a_valid),
    .acc_ready(acc_ready), .count(a_count), .ovf(a_ovf)
  );

  mul_accumulator #(.PROD_W(8), .ACC_W(9), .LEN(4)) u_b (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid),
    .prod_ready(b_ready), .clear(clear), .acc_out(b_acc), .acc_valid(b_valid),
    .acc_ready(acc_ready), .count(b_count), .ovf(b_ovf)
  );

  mul_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid),
    .prod_ready(c_ready), .clear(clear), .acc_out(c_acc), .acc_valid(c_valid),
    .acc_ready(acc_ready), .count(c_count), .ovf(c_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    logic       pv;
    logic       clr;
    logic       ar;
    logic       e_ready;
    logic       e_valid;
    int         e_acc;
    int         e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] p, input logic pv, input logic clr,
                              input logic ar, input logic e_ready, input logic e_valid,
                              input int e_acc, input int e_count, input logic e_ovf);
    vec_t v;
    v.p = p; v.pv = pv; v.clr = clr; v.ar = ar;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_acc = e_acc;
    v.e_count = e_count; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rise.
  task automatic step(input logic [7:0] p, input logic pv, input logic clr, input logic ar);
    @(negedge clk);
    prod = p; prod_valid = pv; clear = clr; acc_ready = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic r, input logic v, input int acc,
                       input int cnt, input logic o);
    chk({tag, ".a_ready"}, int'(a_ready), int'(r));
    chk({tag, ".a_valid"}, int'(a_valid), int'(v));
    chk({tag, ".a_acc"},   int'(a_acc),   acc);
    chk({tag, ".a_count"}, int'(a_count), cnt);
    chk({tag, ".a_ovf"},   int'(a_ovf),   int'(o));
  endtask

  task automatic chk_b(input string tag, input logic r, input logic v, input int acc,
                       input int cnt, input logic o);
    chk({tag, ".b_ready"}, int'(b_ready), int'(r));
    chk({tag, ".b_valid"}, int'(b_valid), int'(v));
    chk({tag, ".b_acc"},   int'(b_acc),   acc);
    chk({tag, ".b_count"}, int'(b_count), cnt);
    chk({tag, ".b_ovf"},   int'(b_ovf),   int'(o));
  endtask

  task automatic chk_c(input string tag, input logic r, input logic v, input int acc,
                       input int cnt, input logic o);
    chk({tag, ".c_ready"}, int'(c_ready), int'(r));
    chk({tag, ".c_valid"}, int'(c_valid), int'(v));
    chk({tag, ".c_acc"},   int'(c_acc),   acc);
    chk({tag, ".c_count"}, int'(c_count), cnt);
    chk({tag, ".c_ovf"},   int'(c_ovf),   int'(o));
  endtask

  // Full reset pulse: check reset values, release, check prod_ready rises.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1; prod = 8'd0; prod_valid = 1'b0; clear = 1'b0; acc_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_a({tag, ".rst"}, 1'b0, 1'b0, 0, 0, 1'b0);
    chk_b({tag, ".rst"}, 1'b0, 1'b0, 0, 0, 1'b0);
    chk_c({tag, ".rst"}, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".a_ready_rel"}, int'(a_ready), 1);
    chk({tag, ".b_ready_rel"}, int'(b_ready), 1);
    chk({tag, ".c_ready_rel"}, int'(c_ready), 1);
  endtask

  initial begin
    rst_n = 1'b1; prod = 8'd0; prod_valid = 1'b0; clear = 1'b0; acc_ready = 1'b0;

    // ---------------- Table for instance A ----------------
    // basic group 3,5,7,9 with consumer always ready
    add(8'd3,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0,  1, 1'b0);
    add(8'd5,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0,  2, 1'b0);
    add(8'd7,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0,  3, 1'b0);
    add(8'd9,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24, 0, 1'b0);
    add(8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24, 0, 1'b0);
    add(8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24, 0, 1'b0);
    // backpressure: same group, consumer stalls 5 cycles, 100 offered in HOLD
    add(8'd3,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24, 1, 1'b0);
    add(8'd5,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24, 2, 1'b0);
    add(8'd7,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24, 3, 1'b0);
    add(8'd9,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add(8'd100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24, 0, 1'b0);
    end
    add(8'd100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24, 0, 1'b0);  // handshake, 100 dropped
    add(8'd100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24, 1, 1'b0);  // now accepted
    add(8'd0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24, 0, 1'b0);  // clear
    // clear mid-group: 10, 20, then clear with 30 offered
    add(8'd10,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24, 1, 1'b0);
    add(8'd20,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24, 2, 1'b0);
    add(8'd30,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24, 0, 1'b0);
    add(8'd1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24, 1, 1'b0);
    add(8'd1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24, 2, 1'b0);
    add(8'd1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24, 3, 1'b0);
    add(8'd1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4,  0, 1'b0);
    add(8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4,  0, 1'b0);
    // clear in HOLD beats handshake; acc_out keeps its value
    add(8'd5,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4,  0, 1'b0);
    add(8'd5,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4,  1, 1'b0);
    add(8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4,  0, 1'b0);

    do_reset("init");
    foreach (vecs[i]) begin
      step(vecs[i].p, vecs[i].pv, vecs[i].clr, vecs[i].ar);
      chk_a($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid,
            vecs[i].e_acc, vecs[i].e_count, vecs[i].e_ovf);
    end

    // ---------------- Overflow on instance B (ACC_W=9) ----------------
    do_reset("ovf");
    step(8'd255, 1'b1, 1'b0, 1'b0); chk_b("ovf1", 1'b1, 1'b0, 0, 1, 1'b0);
    step(8'd255, 1'b1, 1'b0, 1'b0); chk_b("ovf2", 1'b1, 1'b0, 0, 2, 1'b0);
    step(8'd255, 1'b1, 1'b0, 1'b0); chk_b("ovf3", 1'b1, 1'b0, 0, 3, 1'b1);
    step(8'd255, 1'b1, 1'b0, 1'b0); chk_b("ovf4", 1'b0, 1'b1, B_G1, 0, 1'b1);
    step(8'd0,   1'b0, 1'b0, 1'b0); chk_b("ovf_hold", 1'b0, 1'b1, B_G1, 0, 1'b1);
    step(8'd0,   1'b0, 1'b0, 1'b1); chk_b("ovf_hs", 1'b1, 1'b0, B_G1, 0, 1'b0);
    // second group ends with a zero: saturated value must persist
    step(8'd255, 1'b1, 1'b0, 1'b1); chk_b("g2_1", 1'b1, 1'b0, B_G1, 1, 1'b0);
    step(8'd255, 1'b1, 1'b0, 1'b1); chk_b("g2_2", 1'b1, 1'b0, B_G1, 2, 1'b0);
    step(8'd255, 1'b1, 1'b0, 1'b1); chk_b("g2_3", 1'b1, 1'b0, B_G1, 3, 1'b1);
    step(8'd0,   1'b1, 1'b0, 1'b1); chk_b("g2_4", 1'b0, 1'b1, B_G2, 0, 1'b1);
    step(8'd0,   1'b0, 1'b0, 1'b1); chk_b("g2_hs", 1'b1, 1'b0, B_G2, 0, 1'b0);

    // ---------------- Reset in HOLD on instance A ----------------
    do_reset("rmid");
    step(8'd3, 1'b1, 1'b0, 1'b0);
    step(8'd5, 1'b1, 1'b0, 1'b0);
    step(8'd7, 1'b1, 1'b0, 1'b0);
    step(8'd9, 1'b1, 1'b0, 1'b0);
    chk_a("rmid_hold", 1'b0, 1'b1, 24, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_a("rmid_async", 1'b0, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rmid_ready_rel", int'(a_ready), 1);
    step(8'd2, 1'b1, 1'b0, 1'b1); chk_a("rmid2_1", 1'b1, 1'b0, 0, 1, 1'b0);
    step(8'd2, 1'b1, 1'b0, 1'b1);
    step(8'd2, 1'b1, 1'b0, 1'b1);
    step(8'd2, 1'b1, 1'b0, 1'b1); chk_a("rmid2_4", 1'b0, 1'b1, 8, 0, 1'b0);

    // ---------------- LEN=1 on instance C ----------------
    do_reset("len1");
    step(8'd7,  1'b1, 1'b0, 1'b1); chk_c("l1_7",   1'b0, 1'b1, 7,  0, 1'b0);
    step(8'd9,  1'b1, 1'b0, 1'b1); chk_c("l1_hs1", 1'b1, 1'b0, 7,  0, 1'b0);
    step(8'd9,  1'b1, 1'b0, 1'b1); chk_c("l1_9",   1'b0, 1'b1, 9,  0, 1'b0);
    step(8'd11, 1'b1, 1'b0, 1'b1); chk_c("l1_hs2", 1'b1, 1'b0, 9,  0, 1'b0);
    step(8'd11, 1'b1, 1'b0, 1'b1); chk_c("l1_11",  1'b0, 1'b1, 11, 0, 1'b0);
    step(8'd0,  1'b0, 1'b0, 1'b1); chk_c("l1_hs3", 1'b1, 1'b0, 11, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
